// File: rtl/lockstep_req_merge.sv
`default_nettype none
// ============================================================================
// Module   : lockstep_req_merge
// Purpose  : Collects one request per participating core, checks that all
//            copies agree, issues a single merged downstream request and fans
//            the response back to every participating core.
// Revision : 1.0 - initial release
// ============================================================================

module lockstep_req_merge #(
  parameter int NB_CORES = 8,
  parameter int ID_WIDTH = 5,
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         lockstep_mode_i,

  input  logic [NB_CORES-1:0]          core_req_i,
  input  logic [NB_CORES*32-1:0]       core_add_i,
  input  logic [NB_CORES-1:0]          core_wen_i,
  input  logic [NB_CORES*32-1:0]       core_wdata_i,
  input  logic [NB_CORES*4-1:0]        core_be_i,
  input  logic [NB_CORES*ID_WIDTH-1:0] core_id_i,
  output logic [NB_CORES-1:0]          core_gnt_o,
  output logic [NB_CORES-1:0]          core_r_valid_o,
  output logic [31:0]                  core_r_rdata_o,
  output logic [NB_CORES*ID_WIDTH-1:0] core_r_id_o,
  output logic [NB_CORES-1:0]          core_r_opc_o,

  output logic                         req_o,
  output logic [31:0]                  add_o,
  output logic                         wen_o,
  output logic [31:0]                  wdata_o,
  output logic [3:0]                   be_o,
  input  logic                         gnt_i,
  input  logic                         r_valid_i,
  input  logic [31:0]                  r_rdata_i,
  input  logic                         r_opc_i,

  output logic                         mismatch_o,
  output logic                         timeout_o,
  output logic [7:0]                   err_count_o
);

  localparam logic [31:0] c_ERR_RDATA = 32'hBADACCE5;
  localparam logic [7:0]  c_TIMEOUT   = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_ISSUE   = 3'd2,
    S_RESP    = 3'd3,
    S_ERR     = 3'd4
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Captured per-core request fields
  logic [NB_CORES-1:0][31:0]         r_add;
  logic [NB_CORES-1:0]               r_wen;
  logic [NB_CORES-1:0][31:0]         r_wdata;
  logic [NB_CORES-1:0][3:0]          r_be;
  logic [NB_CORES-1:0][ID_WIDTH-1:0] r_id;
  logic [NB_CORES-1:0]               r_captured;
  logic [NB_CORES-1:0]               r_mask;
  logic [7:0]                        r_cnt;

  // Response pulse and error reporting
  logic [NB_CORES-1:0]               r_rsp_valid;
  logic [31:0]                       r_rsp_rdata;
  logic                              r_rsp_opc;
  logic                              r_mismatch;
  logic                              r_timeout;
  logic [7:0]                        r_err_cnt;

  logic [NB_CORES-1:0]               w_mask_now;
  logic [NB_CORES-1:0]               w_gnt;
  logic [NB_CORES-1:0]               w_diff;
  logic                              w_all_captured;
  logic [7:0]                        w_cnt_inc;
  logic                              w_set_mm;
  logic                              w_set_to;
  logic                              w_resp_done;

  assign w_mask_now     = lockstep_mode_i ? {NB_CORES{1'b1}} : NB_CORES'(1);
  assign w_all_captured = ((r_captured & r_mask) == r_mask);
  assign w_cnt_inc      = r_cnt + 8'd1;
  assign w_resp_done    = (r_state == S_RESP) && r_valid_i;

  // Write data only matters for writes; wen/add/be always have to agree.
  always_comb begin
    w_diff = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      w_diff[i] = r_mask[i] &
                  ((r_add[i] != r_add[0]) ||
                   (r_wen[i] != r_wen[0]) ||
                   (r_be[i]  != r_be[0])  ||
                   (!r_wen[0] && (r_wdata[i] != r_wdata[0])));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_gnt        = '0;
    w_set_mm     = 1'b0;
    w_set_to     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt = core_req_i & w_mask_now & ~r_captured;
        if (|w_gnt) begin
          w_state_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        w_gnt = core_req_i & r_mask & ~r_captured;
        // Completion wins over a timeout landing in the same cycle.
        if (w_all_captured) begin
          if (|w_diff) begin
            w_state_next = S_ERR;
            w_set_mm     = 1'b1;
          end else begin
            w_state_next = S_ISSUE;
          end
        end else if (w_cnt_inc == c_TIMEOUT) begin
          w_state_next = S_ERR;
          w_set_to     = 1'b1;
        end
      end
      S_ISSUE: begin
        if (gnt_i) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (r_valid_i) begin
          w_state_next = S_IDLE;
        end
      end
      S_ERR: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_add       <= '0;
      r_wen       <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_id        <= '0;
      r_captured  <= '0;
      r_mask      <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_opc   <= 1'b0;
      r_mismatch  <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      for (int i = 0; i < NB_CORES; i++) begin
        if (w_gnt[i]) begin
          r_add[i]   <= core_add_i[i*32 +: 32];
          r_wen[i]   <= core_wen_i[i];
          r_wdata[i] <= core_wdata_i[i*32 +: 32];
          r_be[i]    <= core_be_i[i*4 +: 4];
          r_id[i]    <= core_id_i[i*ID_WIDTH +: ID_WIDTH];
        end
      end

      if ((r_state == S_ERR) || w_resp_done) begin
        r_captured <= '0;
      end else begin
        r_captured <= r_captured | w_gnt;
      end

      if ((r_state == S_IDLE) && (|w_gnt)) begin
        r_mask <= w_mask_now;
      end

      r_cnt      <= (r_state == S_COLLECT) ? w_cnt_inc : 8'd0;
      r_mismatch <= w_set_mm;
      r_timeout  <= w_set_to;

      // Response pulse lands in the cycle after RESP/ERR completes.
      r_rsp_valid <= '0;
      if (w_resp_done) begin
        r_rsp_valid <= r_captured;
        r_rsp_rdata <= r_rdata_i;
        r_rsp_opc   <= r_opc_i;
      end else if (r_state == S_ERR) begin
        r_rsp_valid <= r_captured;
        r_rsp_rdata <= c_ERR_RDATA;
        r_rsp_opc   <= 1'b1;
      end

      if ((r_state == S_ERR) && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign core_gnt_o     = w_gnt;
  assign core_r_valid_o = r_rsp_valid;
  assign core_r_rdata_o = r_rsp_rdata;
  assign core_r_opc_o   = r_rsp_valid & {NB_CORES{r_rsp_opc}};
  assign core_r_id_o    = r_id;

  assign req_o   = (r_state == S_ISSUE);
  assign add_o   = r_add[0];
  assign wen_o   = r_wen[0];
  assign wdata_o = r_wdata[0];
  assign be_o    = r_be[0];

  assign mismatch_o  = r_mismatch;
  assign timeout_o   = r_timeout;
  assign err_count_o = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lockstep_req_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_lockstep_req_merge
// Purpose  : Directed self-checking bench for lockstep_req_merge.
// Revision : 1.0 - initial release
// ============================================================================

module tb_lockstep_req_merge;

  localparam int NB  = 8;
  localparam int IDW = 5;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rst_ni;
  logic              lockstep_mode_i;
  logic [NB-1:0]     core_req_i;
  logic [NB*32-1:0]  core_add_i;
  logic [NB-1:0]     core_wen_i;
  logic [NB*32-1:0]  core_wdata_i;
  logic [NB*4-1:0]   core_be_i;
  logic [NB*IDW-1:0] core_id_i;
  logic              gnt_i;
  logic              r_valid_i;
  logic [31:0]       r_rdata_i;
  logic              r_opc_i;

  logic [NB-1:0]     core_gnt_o, core_r_valid_o, core_r_opc_o;
  logic [31:0]       core_r_rdata_o;
  logic [NB*IDW-1:0] core_r_id_o;
  logic              req_o, wen_o, mismatch_o, timeout_o;
  logic [31:0]       add_o, wdata_o;
  logic [3:0]        be_o;
  logic [7:0]        err_count_o;

  // Short-timeout copy sharing the same stimulus
  logic [NB-1:0]     t_gnt, t_r_valid, t_r_opc;
  logic [31:0]       t_r_rdata;
  logic [NB*IDW-1:0] t_r_id;
  logic              t_req, t_wen, t_mismatch, t_timeout;
  logic [31:0]       t_add, t_wdata;
  logic [3:0]        t_be;
  logic [7:0]        t_err_count;

  int n_cmp = 0;
  int n_err = 0;

  lockstep_req_merge #(.NB_CORES(NB), .ID_WIDTH(IDW), .TIMEOUT(255)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .lockstep_mode_i(lockstep_mode_i),
    .core_req_i(core_req_i), .core_add_i(core_add_i), .core_wen_i(core_wen_i),
    .core_wdata_i(core_wdata_i), .core_be_i(core_be_i), .core_id_i(core_id_i),
    .core_gnt_o(core_gnt_o), .core_r_valid_o(core_r_valid_o),
    .core_r_rdata_o(core_r_rdata_o), .core_r_id_o(core_r_id_o),
    .core_r_opc_o(core_r_opc_o),
    .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o),
    .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i), .r_opc_i(r_opc_i),
    .mismatch_o(mismatch_o), .timeout_o(timeout_o), .err_count_o(err_count_o)
  );

  lockstep_req_merge #(.NB_CORES(NB), .ID_WIDTH(IDW), .TIMEOUT(4)) u_dut_to (
    .clk_i(clk_i), .rst_ni(rst_ni), .lockstep_mode_i(lockstep_mode_i),
    .core_req_i(core_req_i), .core_add_i(core_add_i), .core_wen_i(core_wen_i),
    .core_wdata_i(core_wdata_i), .core_be_i(core_be_i), .core_id_i(core_id_i),
    .core_gnt_o(t_gnt), .core_r_valid_o(t_r_valid),
    .core_r_rdata_o(t_r_rdata), .core_r_id_o(t_r_id),
    .core_r_opc_o(t_r_opc),
    .req_o(t_req), .add_o(t_add), .wen_o(t_wen), .wdata_o(t_wdata), .be_o(t_be),
    .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i), .r_opc_i(r_opc_i),
    .mismatch_o(t_mismatch), .timeout_o(t_timeout), .err_count_o(t_err_count)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    core_req_i = '0;
    gnt_i      = 1'b0;
    r_valid_i  = 1'b0;
    r_rdata_i  = '0;
    r_opc_i    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic load_all(input logic [31:0] add, input logic wen,
                          input logic [31:0] wdata, input logic [3:0] be);
    for (int i = 0; i < NB; i++) begin
      core_add_i[i*32 +: 32]   = add;
      core_wen_i[i]            = wen;
      core_wdata_i[i*32 +: 32] = wdata;
      core_be_i[i*4 +: 4]      = be;
    end
  endtask

  function automatic logic [NB*IDW-1:0] exp_ids();
    logic [NB*IDW-1:0] v;
    for (int i = 0; i < NB; i++) v[i*IDW +: IDW] = IDW'(i + 3);
    return v;
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    n_cmp++; if (req_o !== 1'b0) begin n_err++; $display("FAIL reset.req_o: got %b want 0", req_o); end
    n_cmp++; if (core_r_valid_o !== '0) begin n_err++; $display("FAIL reset.r_valid: got %h want 00", core_r_valid_o); end
    n_cmp++; if (err_count_o !== 8'd0) begin n_err++; $display("FAIL reset.err_count: got %0d want 0", err_count_o); end
    n_cmp++; if ({mismatch_o, timeout_o, core_gnt_o, add_o} !== '0) begin
      n_err++; $display("FAIL reset.outputs: mm=%b to=%b gnt=%h add=%h want all 0", mismatch_o, timeout_o, core_gnt_o, add_o);
    end
    tick();
  endtask

  task automatic test_write_all();
    int n_req = 0;
    do_reset();
    lockstep_mode_i = 1'b1;
    load_all(32'h10204400, 1'b0, 32'd1, 4'hF);
    for (int c = 0; c < 6; c++) begin
      core_req_i = (c == 0) ? '1 : '0;
      gnt_i      = (c == 2);
      r_valid_i  = (c == 3);
      r_rdata_i  = 32'h55AA0001;
      r_opc_i    = 1'b0;
      @(negedge clk_i);
      if (req_o) n_req++;
      if (c == 0) begin
        n_cmp++; if (core_gnt_o !== 8'hFF) begin n_err++; $display("FAIL write.gnt: got %h want ff", core_gnt_o); end
      end
      if (c == 1) begin
        n_cmp++; if (req_o !== 1'b0 || core_gnt_o !== '0) begin n_err++; $display("FAIL write.c1: req=%b gnt=%h want 0/00", req_o, core_gnt_o); end
      end
      if (c == 2) begin
        n_cmp++;
        if (req_o !== 1'b1 || add_o !== 32'h10204400 || wen_o !== 1'b0 || wdata_o !== 32'd1 || be_o !== 4'hF) begin
          n_err++; $display("FAIL write.req: req=%b add=%h wen=%b wdata=%h be=%h want 1/10204400/0/1/f", req_o, add_o, wen_o, wdata_o, be_o);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (core_r_valid_o !== 8'hFF || core_r_opc_o !== 8'h00 || core_r_rdata_o !== 32'h55AA0001) begin
          n_err++; $display("FAIL write.rsp: valid=%h opc=%h rdata=%h want ff/00/55aa0001", core_r_valid_o, core_r_opc_o, core_r_rdata_o);
        end
        n_cmp++; if (core_r_id_o !== exp_ids()) begin n_err++; $display("FAIL write.r_id: got %h want %h", core_r_id_o, exp_ids()); end
      end
      if (c == 5) begin
        n_cmp++; if (core_r_valid_o !== '0) begin n_err++; $display("FAIL write.pulse: got %h want 00", core_r_valid_o); end
      end
      tick();
    end
    n_cmp++; if (n_req !== 1) begin n_err++; $display("FAIL write.req_count: got %0d want 1", n_req); end
  endtask

  task automatic test_mismatch();
    int n_req = 0;
    do_reset();
    lockstep_mode_i = 1'b1;
    load_all(32'h10204400, 1'b0, 32'd1, 4'hF);
    core_wdata_i[5*32 +: 32] = 32'd2;
    for (int c = 0; c < 5; c++) begin
      core_req_i = (c == 0) ? '1 : '0;
      gnt_i      = 1'b1;
      @(negedge clk_i);
      if (req_o) n_req++;
      if (c == 2) begin
        n_cmp++; if (mismatch_o !== 1'b1 || timeout_o !== 1'b0) begin n_err++; $display("FAIL mm.pulse: mm=%b to=%b want 1/0", mismatch_o, timeout_o); end
      end
      if (c == 3) begin
        n_cmp++;
        if (core_r_valid_o !== 8'hFF || core_r_opc_o !== 8'hFF || core_r_rdata_o !== 32'hBADACCE5 || mismatch_o !== 1'b0) begin
          n_err++; $display("FAIL mm.rsp: valid=%h opc=%h rdata=%h mm=%b want ff/ff/badacce5/0", core_r_valid_o, core_r_opc_o, core_r_rdata_o, mismatch_o);
        end
        n_cmp++; if (err_count_o !== 8'd1) begin n_err++; $display("FAIL mm.err_count: got %0d want 1", err_count_o); end
      end
      tick();
    end
    gnt_i = 1'b0;
    n_cmp++; if (n_req !== 0) begin n_err++; $display("FAIL mm.no_req: got %0d req cycles want 0", n_req); end
  endtask

  task automatic test_timeout();
    do_reset();
    lockstep_mode_i = 1'b1;
    load_all(32'h00000100, 1'b1, 32'd0, 4'hF);
    for (int c = 0; c < 8; c++) begin
      core_req_i = (c == 0) ? 8'h7F : 8'h00;
      @(negedge clk_i);
      if (c >= 1 && c <= 4) begin
        n_cmp++; if (t_timeout !== 1'b0) begin n_err++; $display("FAIL to.early c%0d: got %b want 0", c, t_timeout); end
      end
      if (c == 5) begin
        n_cmp++; if (t_timeout !== 1'b1 || t_mismatch !== 1'b0) begin n_err++; $display("FAIL to.pulse: to=%b mm=%b want 1/0", t_timeout, t_mismatch); end
      end
      if (c == 6) begin
        n_cmp++;
        if (t_r_valid !== 8'h7F || t_r_opc !== 8'h7F || t_r_rdata !== 32'hBADACCE5 || t_err_count !== 8'd1) begin
          n_err++; $display("FAIL to.rsp: valid=%h opc=%h rdata=%h cnt=%0d want 7f/7f/badacce5/1", t_r_valid, t_r_opc, t_r_rdata, t_err_count);
        end
      end
      tick();
    end
  endtask

  task automatic test_staggered();
    int gcnt [NB];
    int n_hs = 0;
    do_reset();
    lockstep_mode_i = 1'b1;
    load_all(32'h00000800, 1'b1, 32'd0, 4'hF);
    for (int i = 0; i < NB; i++) begin
      core_wdata_i[i*32 +: 32] = 32'(i);
      gcnt[i] = 0;
    end
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < NB; i++) core_req_i[i] = (c >= i) && (c <= 13);
      gnt_i     = (c == 11);
      r_valid_i = (c == 13);
      r_rdata_i = 32'hCAFEF00D;
      r_opc_i   = 1'b1;
      @(negedge clk_i);
      for (int i = 0; i < NB; i++) if (core_gnt_o[i]) gcnt[i]++;
      if (req_o && gnt_i) n_hs++;
      if (c <= 7) begin
        n_cmp++; if (core_gnt_o !== (NB'(1) << c)) begin n_err++; $display("FAIL stag.gnt c%0d: got %h want %h", c, core_gnt_o, NB'(1) << c); end
      end
      if (c == 8) begin
        n_cmp++; if (req_o !== 1'b0) begin n_err++; $display("FAIL stag.early_req: got %b want 0", req_o); end
      end
      if (c == 9 || c == 10) begin
        n_cmp++;
        if (req_o !== 1'b1 || add_o !== 32'h00000800 || wen_o !== 1'b1 || be_o !== 4'hF) begin
          n_err++; $display("FAIL stag.req c%0d: req=%b add=%h wen=%b be=%h want 1/00000800/1/f", c, req_o, add_o, wen_o, be_o);
        end
      end
      if (c == 14) begin
        n_cmp++;
        if (core_r_valid_o !== 8'hFF || core_r_opc_o !== 8'hFF || core_r_rdata_o !== 32'hCAFEF00D) begin
          n_err++; $display("FAIL stag.rsp: valid=%h opc=%h rdata=%h want ff/ff/cafef00d", core_r_valid_o, core_r_opc_o, core_r_rdata_o);
        end
      end
      tick();
    end
    for (int i = 0; i < NB; i++) begin
      n_cmp++; if (gcnt[i] !== 1) begin n_err++; $display("FAIL stag.gcount core%0d: got %0d want 1", i, gcnt[i]); end
    end
    n_cmp++; if (n_hs !== 1) begin n_err++; $display("FAIL stag.handshakes: got %0d want 1", n_hs); end
  endtask

  task automatic test_mode0();
    int g1 = 0;
    do_reset();
    lockstep_mode_i = 1'b0;
    load_all(32'hDEAD0000, 1'b0, 32'hFFFFFFFF, 4'hF);
    core_add_i[31:0] = 32'h1A2B3C40;
    core_wen_i[0]    = 1'b1;
    core_be_i[3:0]   = 4'h3;
    for (int c = 0; c < 7; c++) begin
      core_req_i = (c == 0) ? 8'h03 : 8'h02;
      gnt_i      = (c == 2);
      r_valid_i  = (c == 3);
      r_rdata_i  = 32'h12345678;
      r_opc_i    = 1'b0;
      @(negedge clk_i);
      if (core_gnt_o[1]) g1++;
      if (c == 0) begin
        n_cmp++; if (core_gnt_o !== 8'h01) begin n_err++; $display("FAIL m0.gnt: got %h want 01", core_gnt_o); end
      end
      if (c == 2) begin
        n_cmp++;
        if (req_o !== 1'b1 || add_o !== 32'h1A2B3C40 || wen_o !== 1'b1 || be_o !== 4'h3) begin
          n_err++; $display("FAIL m0.req: req=%b add=%h wen=%b be=%h want 1/1a2b3c40/1/3", req_o, add_o, wen_o, be_o);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (core_r_valid_o !== 8'h01 || core_r_rdata_o !== 32'h12345678 || core_r_opc_o !== 8'h00 || core_r_id_o[IDW-1:0] !== 5'd3) begin
          n_err++; $display("FAIL m0.rsp: valid=%h rdata=%h opc=%h id=%h want 01/12345678/00/03", core_r_valid_o, core_r_rdata_o, core_r_opc_o, core_r_id_o[IDW-1:0]);
        end
      end
      tick();
    end
    n_cmp++; if (g1 !== 0) begin n_err++; $display("FAIL m0.core1_gnt: got %0d grants want 0", g1); end
  endtask

  task automatic test_reset_mid();
    int n_rv = 0;
    do_reset();
    lockstep_mode_i = 1'b1;
    load_all(32'h10204400, 1'b0, 32'd1, 4'hF);
    for (int c = 0; c < 3; c++) begin
      core_req_i = (c == 0) ? '1 : '0;
      @(negedge clk_i);
      if (c == 2) begin
        n_cmp++; if (req_o !== 1'b1) begin n_err++; $display("FAIL rmid.issue: got %b want 1", req_o); end
        #1 rst_ni = 1'b0;
        #1;
        n_cmp++; if (req_o !== 1'b0) begin n_err++; $display("FAIL rmid.req_drop: got %b want 0", req_o); end
      end
      if (c < 2) tick();
    end
    tick();
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      gnt_i = 1'b1; r_valid_i = 1'b1;
      @(negedge clk_i);
      if (core_r_valid_o !== '0) n_rv++;
      tick();
    end
    gnt_i = 1'b0; r_valid_i = 1'b0;
    n_cmp++; if (n_rv !== 0) begin n_err++; $display("FAIL rmid.no_rsp: got %0d valid cycles want 0", n_rv); end
    n_cmp++; if (err_count_o !== 8'd0) begin n_err++; $display("FAIL rmid.err_count: got %0d want 0", err_count_o); end
    for (int c = 0; c < 5; c++) begin
      core_req_i = (c == 0) ? '1 : '0;
      gnt_i      = (c == 2);
      r_valid_i  = (c == 3);
      r_rdata_i  = 32'h0000BEEF;
      @(negedge clk_i);
      if (c == 2) begin
        n_cmp++; if (req_o !== 1'b1 || add_o !== 32'h10204400) begin n_err++; $display("FAIL rmid.after_req: req=%b add=%h want 1/10204400", req_o, add_o); end
      end
      if (c == 4) begin
        n_cmp++; if (core_r_valid_o !== 8'hFF || core_r_rdata_o !== 32'h0000BEEF) begin n_err++; $display("FAIL rmid.after_rsp: valid=%h rdata=%h want ff/0000beef", core_r_valid_o, core_r_rdata_o); end
      end
      tick();
    end
  endtask

  task automatic test_err_saturate();
    do_reset();
    lockstep_mode_i = 1'b1;
    load_all(32'h00000040, 1'b0, 32'd7, 4'hF);
    core_be_i[2*4 +: 4] = 4'h1;
    for (int n = 0; n < 256; n++) begin
      for (int c = 0; c < 4; c++) begin
        core_req_i = (c == 0) ? '1 : '0;
        tick();
      end
    end
    @(negedge clk_i);
    n_cmp++; if (err_count_o !== 8'd255) begin n_err++; $display("FAIL sat.err_count: got %0d want 255", err_count_o); end
    tick();
  endtask

  initial begin
    rst_ni          = 1'b1;
    lockstep_mode_i = 1'b1;
    core_req_i      = '0;
    core_add_i      = '0;
    core_wen_i      = '1;
    core_wdata_i    = '0;
    core_be_i       = '0;
    gnt_i           = 1'b0;
    r_valid_i       = 1'b0;
    r_rdata_i       = '0;
    r_opc_i         = 1'b0;
    for (int i = 0; i < NB; i++) core_id_i[i*IDW +: IDW] = IDW'(i + 3);
    #2;
    test_reset();
    test_write_all();
    test_mismatch();
    test_timeout();
    test_staggered();
    test_mode0();
    test_reset_mid();
    test_err_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
